// File: rtl/pcie_rx_cpl_tag_check.sv
// Completion TLP checker: validates tag, status and byte count against
// the outstanding-read tag table and passes completions through with an error code.
module pcie_rx_cpl_tag_check #(
  parameter int TLP_DATA_WIDTH = 256,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 32,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TLP_DATA_WIDTH-1:0] in_tlp_data,
  input  logic [TLP_STRB_WIDTH-1:0] in_tlp_strb,
  input  logic [TLP_HDR_WIDTH-1:0]  in_tlp_hdr,
  input  logic                      in_tlp_valid,
  input  logic                      in_tlp_sop,
  input  logic                      in_tlp_eop,
  output logic                      in_tlp_ready,
  output logic [TLP_DATA_WIDTH-1:0] out_tlp_data,
  output logic [TLP_STRB_WIDTH-1:0] out_tlp_strb,
  output logic [TLP_HDR_WIDTH-1:0]  out_tlp_hdr,
  output logic                      out_tlp_valid,
  output logic                      out_tlp_sop,
  output logic                      out_tlp_eop,
  output logic [3:0]                out_tlp_error,
  input  logic                      out_tlp_ready,
  input  logic                      tag_alloc_valid,
  input  logic [TAG_WIDTH-1:0]      tag_alloc_tag,
  input  logic [12:0]               tag_alloc_bytes,
  output logic                      tag_done_valid,
  output logic [TAG_WIDTH-1:0]      tag_done_tag,
  output logic [3:0]                tag_done_error
);

  localparam int NTAGS = 1 << TAG_WIDTH;

  logic [NTAGS-1:0] active;
  logic [12:0]      remaining [NTAGS];

  logic [TAG_WIDTH-1:0] tag;
  logic                 tag_hi_zero;
  logic                 hit;
  logic [12:0]          cur_rem;
  logic [12:0]          len_bytes;
  logic [12:0]          payload;
  logic [12:0]          bc;
  logic [2:0]           status;
  logic [3:0]           sop_err;
  logic                 sop_done;
  logic [3:0]           cur_err;
  logic                 accept;

  assign in_tlp_ready = !out_tlp_valid || out_tlp_ready;
  assign accept       = in_tlp_valid && in_tlp_ready;

  assign tag         = in_tlp_hdr[40 +: TAG_WIDTH];
  assign tag_hi_zero = (in_tlp_hdr[47:40] >> TAG_WIDTH) == 8'd0;
  assign hit         = active[tag] && tag_hi_zero;
  assign cur_rem     = remaining[tag];
  assign status      = in_tlp_hdr[79:77];

  // Zero-encoded maxima: length 0 is 1024 DW, byte count 0 is 4096 bytes
  assign len_bytes = (in_tlp_hdr[105:96] == 10'd0) ? 13'd4096
                   : {1'b0, in_tlp_hdr[105:96], 2'b00};
  assign payload   = len_bytes - {11'd0, in_tlp_hdr[33:32]};
  assign bc        = (in_tlp_hdr[75:64] == 12'd0) ? 13'd4096
                   : {1'b0, in_tlp_hdr[75:64]};

  always_comb begin
    sop_err  = 4'd0;
    sop_done = 1'b0;
    if (!hit) begin
      sop_err = 4'd1;
    end else if (status != 3'd0) begin
      sop_err  = 4'd2;
      sop_done = 1'b1;
    end else if (bc != cur_rem) begin
      sop_err  = 4'd3;
      sop_done = 1'b1;
    end else if (payload >= bc) begin
      sop_done = 1'b1;
    end
  end

  // Allocation is written last so it overrides a same-cycle completion update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
      for (int i = 0; i < NTAGS; i++) begin
        remaining[i] <= 13'd0;
      end
    end else begin
      if (accept && in_tlp_sop && hit) begin
        if (sop_done) begin
          active[tag] <= 1'b0;
        end else begin
          remaining[tag] <= bc - payload;
        end
      end
      if (tag_alloc_valid) begin
        active[tag_alloc_tag]    <= 1'b1;
        remaining[tag_alloc_tag] <= tag_alloc_bytes;
      end
    end
  end

  // cur_err resets to 1 so orphan continuation beats after reset are flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tlp_data   <= '0;
      out_tlp_strb   <= '0;
      out_tlp_hdr    <= '0;
      out_tlp_valid  <= 1'b0;
      out_tlp_sop    <= 1'b0;
      out_tlp_eop    <= 1'b0;
      out_tlp_error  <= 4'd0;
      cur_err        <= 4'd1;
      tag_done_valid <= 1'b0;
      tag_done_tag   <= '0;
      tag_done_error <= 4'd0;
    end else begin
      tag_done_valid <= 1'b0;
      if (in_tlp_ready) begin
        out_tlp_valid <= in_tlp_valid;
        if (in_tlp_valid) begin
          out_tlp_data <= in_tlp_data;
          out_tlp_strb <= in_tlp_strb;
          out_tlp_hdr  <= in_tlp_hdr;
          out_tlp_sop  <= in_tlp_sop;
          out_tlp_eop  <= in_tlp_eop;
          if (in_tlp_sop) begin
            out_tlp_error  <= sop_err;
            cur_err        <= sop_err;
            tag_done_valid <= sop_done;
            tag_done_tag   <= tag;
            tag_done_error <= sop_err;
          end else begin
            out_tlp_error <= cur_err;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pcie_rx_cpl_tag_check.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and randomized completions checked against a tag-table reference model.
module tb_pcie_rx_cpl_tag_check;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] in_tlp_data = '0;
  logic [7:0]   in_tlp_strb = '0;
  logic [127:0] in_tlp_hdr = '0;
  logic         in_tlp_valid = 1'b0;
  logic         in_tlp_sop = 1'b0;
  logic         in_tlp_eop = 1'b0;
  logic         in_tlp_ready;
  logic [255:0] out_tlp_data;
  logic [7:0]   out_tlp_strb;
  logic [127:0] out_tlp_hdr;
  logic         out_tlp_valid;
  logic         out_tlp_sop;
  logic         out_tlp_eop;
  logic [3:0]   out_tlp_error;
  logic         out_tlp_ready = 1'b1;
  logic         tag_alloc_valid = 1'b0;
  logic [4:0]   tag_alloc_tag = '0;
  logic [12:0]  tag_alloc_bytes = '0;
  logic         tag_done_valid;
  logic [4:0]   tag_done_tag;
  logic [3:0]   tag_done_error;

  int checks = 0;
  int errors = 0;

  bit m_act [32];
  int m_rem [32];

  typedef struct {
    int at; int ab; int tag; int len; int st; int bc; int la; int err; int done;
  } vec_t;
  vec_t vecs [15];

  pcie_rx_cpl_tag_check dut (
    .clk(clk), .rst(rst),
    .in_tlp_data(in_tlp_data), .in_tlp_strb(in_tlp_strb),
    .in_tlp_hdr(in_tlp_hdr), .in_tlp_valid(in_tlp_valid),
    .in_tlp_sop(in_tlp_sop), .in_tlp_eop(in_tlp_eop),
    .in_tlp_ready(in_tlp_ready),
    .out_tlp_data(out_tlp_data), .out_tlp_strb(out_tlp_strb),
    .out_tlp_hdr(out_tlp_hdr), .out_tlp_valid(out_tlp_valid),
    .out_tlp_sop(out_tlp_sop), .out_tlp_eop(out_tlp_eop),
    .out_tlp_error(out_tlp_error), .out_tlp_ready(out_tlp_ready),
    .tag_alloc_valid(tag_alloc_valid), .tag_alloc_tag(tag_alloc_tag),
    .tag_alloc_bytes(tag_alloc_bytes),
    .tag_done_valid(tag_done_valid), .tag_done_tag(tag_done_tag),
    .tag_done_error(tag_done_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mkhdr(int tag, int len, int st,
                                         int bc, int la);
    logic [127:0] h;
    h = '0;
    h[127:120] = 8'h4A;
    h[105:96]  = len[9:0];
    h[79:77]   = st[2:0];
    h[75:64]   = bc[11:0];
    h[47:40]   = tag[7:0];
    h[38:32]   = la[6:0];
    return h;
  endfunction

  function automatic logic [255:0] rdata();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Reference: byte accounting per tag, straight from the completion rules
  function automatic void model_cpl(input int tag8, input int len,
                                    input int st, input int bc, input int la,
                                    output int err, output int done);
    int t, bcf, pay;
    t = tag8 % 32;
    done = 0;
    err = 0;
    if (tag8 > 31 || !m_act[t]) begin
      err = 1;
    end else if (st != 0) begin
      err = 2; done = 1; m_act[t] = 0;
    end else begin
      bcf = (bc % 4096 == 0) ? 4096 : bc % 4096;
      pay = ((len % 1024 == 0) ? 1024 : len % 1024) * 4 - (la % 4);
      if (bcf != m_rem[t]) begin
        err = 3; done = 1; m_act[t] = 0;
      end else if (pay >= bcf) begin
        done = 1; m_act[t] = 0;
      end else begin
        m_rem[t] = bcf - pay;
      end
    end
  endfunction

  task automatic do_alloc(input int tag, input int bytes);
    tag_alloc_valid = 1'b1;
    tag_alloc_tag   = tag[4:0];
    tag_alloc_bytes = bytes[12:0];
    @(posedge clk); #1;
    tag_alloc_valid = 1'b0;
    m_act[tag] = 1;
    m_rem[tag] = bytes;
  endtask

  task automatic send(input logic [127:0] hdr, input bit sop, input bit eop,
                      input logic [255:0] d, input int exp_err,
                      input int exp_done, input string nm);
    int w;
    logic [4:0] etag;
    w = 0;
    etag = hdr[44:40];
    in_tlp_hdr   = hdr;
    in_tlp_data  = d;
    in_tlp_strb  = 8'hFF;
    in_tlp_sop   = sop;
    in_tlp_eop   = eop;
    in_tlp_valid = 1'b1;
    while (!in_tlp_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got in_tlp_ready 0 expected 1", nm);
    end
    @(posedge clk); #1;
    in_tlp_valid = 1'b0;
    chk({nm, "_valid"}, out_tlp_valid, 1);
    chk({nm, "_sop"}, out_tlp_sop, sop);
    chk({nm, "_eop"}, out_tlp_eop, eop);
    chk({nm, "_data"}, out_tlp_data, d);
    chk({nm, "_hdr"}, out_tlp_hdr, hdr);
    chk({nm, "_err"}, out_tlp_error, exp_err);
    chk({nm, "_done"}, tag_done_valid, exp_done);
    if (exp_done != 0) begin
      chk({nm, "_dtag"}, tag_done_tag, etag);
      chk({nm, "_derr"}, tag_done_error, exp_err);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_valid"}, out_tlp_valid, 0);
    chk({nm, "_sop"}, out_tlp_sop, 0);
    chk({nm, "_eop"}, out_tlp_eop, 0);
    chk({nm, "_err"}, out_tlp_error, 0);
    chk({nm, "_done"}, tag_done_valid, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_act[i] = 0;
      m_rem[i] = 0;
    end
  endtask

  initial begin
    logic [127:0] h;
    logic [255:0] d0, d1;
    int e, dn;

    vecs = '{
      '{3, 64, 3, 16, 0, 64, 0, 0, 1},
      '{-1, 0, 3, 16, 0, 64, 0, 1, 0},
      '{5, 256, 5, 32, 0, 256, 0, 0, 0},
      '{-1, 0, 5, 32, 0, 128, 0, 0, 1},
      '{-1, 0, 7, 8, 0, 32, 0, 1, 0},
      '{2, 128, 2, 32, 1, 128, 0, 2, 1},
      '{-1, 0, 2, 32, 0, 128, 0, 1, 0},
      '{1, 512, 1, 64, 0, 256, 0, 3, 1},
      '{6, 4096, 6, 0, 0, 4096, 0, 0, 1},
      '{8, 10, 8, 3, 0, 10, 2, 0, 1},
      '{3, 64, 35, 16, 0, 64, 0, 1, 0},
      '{9, 100, 9, 8, 0, 100, 3, 0, 0},
      '{-1, 0, 9, 18, 0, 71, 0, 0, 1},
      '{10, 100, 10, 8, 4, 100, 0, 2, 1},
      '{11, 200, 11, 8, 2, 200, 0, 2, 1}
    };
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].at >= 0) do_alloc(vecs[i].at, vecs[i].ab);
      model_cpl(vecs[i].tag, vecs[i].len, vecs[i].st, vecs[i].bc,
                vecs[i].la, e, dn);
      h = mkhdr(vecs[i].tag, vecs[i].len, vecs[i].st, vecs[i].bc, vecs[i].la);
      send(h, 1, 1, rdata(), vecs[i].err, vecs[i].done,
           $sformatf("vec%0d", i));
    end

    // 3-beat completion on a never-allocated tag
    h = mkhdr(7, 24, 0, 96, 0);
    model_cpl(7, 24, 0, 96, 0, e, dn);
    send(h, 1, 0, rdata(), 1, 0, "unexp_b0");
    send(h, 0, 0, rdata(), 1, 0, "unexp_b1");
    send(h, 0, 1, rdata(), 1, 0, "unexp_b2");

    // Backpressure for 4 cycles mid-TLP
    do_alloc(12, 96);
    h = mkhdr(12, 24, 0, 96, 0);
    model_cpl(12, 24, 0, 96, 0, e, dn);
    d0 = rdata();
    d1 = rdata();
    send(h, 1, 0, d0, 0, 1, "bp_b0");
    out_tlp_ready = 1'b0;
    in_tlp_data   = d1;
    in_tlp_sop    = 1'b0;
    in_tlp_eop    = 1'b0;
    in_tlp_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", out_tlp_data, d0);
      chk("bp_hold_sop", out_tlp_sop, 1);
      chk("bp_hold_valid", out_tlp_valid, 1);
      chk("bp_in_ready", in_tlp_ready, 0);
      chk("bp_done_once", tag_done_valid, 0);
    end
    out_tlp_ready = 1'b1;
    @(posedge clk); #1;
    in_tlp_valid = 1'b0;
    chk("bp_b1_data", out_tlp_data, d1);
    chk("bp_b1_sop", out_tlp_sop, 0);
    chk("bp_b1_err", out_tlp_error, 0);
    send(h, 0, 1, rdata(), 0, 0, "bp_b2");

    // Same-cycle allocation and completion on tag 4: allocation wins
    do_alloc(4, 100);
    model_cpl(4, 8, 0, 100, 0, e, dn);
    m_act[4] = 1;
    m_rem[4] = 200;
    tag_alloc_valid = 1'b1;
    tag_alloc_tag   = 5'd4;
    tag_alloc_bytes = 13'd200;
    send(mkhdr(4, 8, 0, 100, 0), 1, 1, rdata(), 0, 0, "same_cyc");
    tag_alloc_valid = 1'b0;
    model_cpl(4, 50, 0, 200, 0, e, dn);
    send(mkhdr(4, 50, 0, 200, 0), 1, 1, rdata(), 0, 1, "same_cyc_next");

    // Reset in the middle of a TLP
    do_alloc(13, 64);
    model_cpl(13, 8, 0, 64, 0, e, dn);
    send(mkhdr(13, 8, 0, 64, 0), 1, 0, rdata(), 0, 0, "mid_sop");
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(mkhdr(13, 8, 0, 64, 0), 0, 1, rdata(), 1, 0, "post_rst_orphan");
    model_cpl(13, 8, 0, 32, 0, e, dn);
    send(mkhdr(13, 8, 0, 32, 0), 1, 1, rdata(), e, dn, "post_rst_tag");

    // Randomized traffic against the reference model
    for (int it = 0; it < 400; it++) begin
      int r, t8, t, len, st, bc, la, at, ab;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        do_alloc($urandom_range(0, 7), $urandom_range(1, 4096));
      end else begin
        t8 = ($urandom_range(0, 19) == 0) ? $urandom_range(32, 255)
                                          : $urandom_range(0, 7);
        t  = t8 % 32;
        st = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
        if (m_act[t] && $urandom_range(0, 4) != 0) bc = m_rem[t];
        else bc = $urandom_range(0, 4095);
        len = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 200);
        la  = $urandom_range(0, 127);
        model_cpl(t8, len, st, bc, la, e, dn);
        if ($urandom_range(0, 7) == 0) begin
          at = $urandom_range(0, 7);
          ab = $urandom_range(1, 4096);
          tag_alloc_valid = 1'b1;
          tag_alloc_tag   = at[4:0];
          tag_alloc_bytes = ab[12:0];
          m_act[at] = 1;
          m_rem[at] = ab;
        end
        send(mkhdr(t8, len, st, bc, la), 1, 1, rdata(), e, dn,
             $sformatf("rnd%0d", it));
        tag_alloc_valid = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
